// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and constants for the display arbiter slice.
//               Word/digit widths, FSM state encoding and a width helper
//               used for the slice counter and round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  localparam int DIS_W   = 32;  // width of one hex display word
  localparam int DIGIT_W = 4;   // width of one hex digit

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_arbiter_if
// Description : Request/grant/display bundle between the data sources and
//               the display arbiter.
//   req      : per-source level request
//   req_data : source i word in bits [32i+31:32i]
//   grant    : one-hot owner (zero when idle)
//   dis_data : word forwarded to led_driver
//   disp_en  : led_driver enable
//   master = sources side, slave = arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_arbiter_if #(
  parameter int N_REQ = 3
);
  import disp_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [DIS_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]       grant;
  logic [DIS_W-1:0]       dis_data;
  logic                   disp_en;

  modport master (output req, output req_data,
                  input  grant, input dis_data, input disp_en);
  modport slave  (input  req, input req_data,
                  output grant, output dis_data, output disp_en);
endinterface
`default_nettype wire

// File: rtl/disp_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin winner search. Scans ptr+1,
//               ptr+2, ... ptr+N_REQ (mod N_REQ), so the requester at ptr
//               is considered last. excl_owner removes ptr from the scan.
//   req_i        : request vector
//   ptr_i        : last granted index
//   excl_owner_i : skip the requester at ptr_i
//   valid_o      : a winner exists
//   onehot_o     : winner as one-hot
//   idx_o        : winner as index
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import disp_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             excl_owner_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] onehot_o,
  output logic [PTR_W-1:0] idx_o
);

  int               c;
  logic [PTR_W-1:0] cidx;

  always_comb begin
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    c        = 0;
    cidx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c    = (int'(ptr_i) + k) % N_REQ;
      cidx = c[PTR_W-1:0];
      if (!valid_o && req_i[cidx] && !(excl_owner_i && (cidx == ptr_i))) begin
        valid_o        = 1'b1;
        onehot_o[cidx] = 1'b1;
        idx_o          = cidx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_arbiter
// Description : Round-robin owner of the 8-digit display with a minimum and
//               maximum time slice. Selects the owner's word as dis_data and
//               drives led_driver's enable.
//   clk_50mhz : system clock
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of disp_arbiter_if (req, req_data in;
//               grant, dis_data, disp_en out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MIN_SLICE = 5_000_000,
  parameter int MAX_SLICE = 50_000_000
) (
  input  logic           clk_50mhz,
  input  logic           rst_n,
  disp_arbiter_if.slave  bus
);

  localparam int CNT_W = cnt_width(MAX_SLICE);
  localparam int PTR_W = cnt_width(N_REQ);
  localparam logic [CNT_W-1:0] C_MIN_M1 = CNT_W'(MIN_SLICE - 1);
  localparam logic [CNT_W-1:0] C_MAX_M1 = CNT_W'(MAX_SLICE - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [DIS_W-1:0]   dis_q,   dis_d;
  logic               en_q,    en_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;

  logic               excl;
  logic               pick_valid;
  logic [N_REQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               owner_req;
  logic               rel_a;
  logic               rel_b;

  logic [DIS_W-1:0]   slot [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign slot[gi] = bus.req_data[DIS_W*gi +: DIS_W];
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i        (bus.req),
    .ptr_i        (ptr_q),
    .excl_owner_i (excl),
    .valid_o      (pick_valid),
    .onehot_o     (pick_onehot),
    .idx_o        (pick_idx)
  );

  // While owning, ptr_q holds the owner's index.
  assign owner_req = |(bus.req & grant_q);
  assign rel_a     = !owner_req && (cnt_q >= C_MIN_M1);
  assign rel_b     = (cnt_q >= C_MAX_M1) && (|(bus.req & ~grant_q));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dis_d   = dis_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    excl    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          dis_d   = slot[pick_idx];
          en_d    = 1'b1;
          cnt_d   = '0;
          ptr_d   = pick_idx;
          state_d = S_OWN;
        end
      end

      S_OWN: begin
        cnt_d = (cnt_q == C_MAX_M1) ? cnt_q : cnt_q + 1'b1;
        if (owner_req) begin
          dis_d = slot[ptr_q];
        end
        if (rel_a || rel_b) begin
          // A forced (max-slice) handover must go to someone else; a
          // voluntary release may return to the owner if it re-requests.
          excl = !rel_a;
          if (pick_valid) begin
            grant_d = pick_onehot;
            dis_d   = slot[pick_idx];
            cnt_d   = '0;
            ptr_d   = pick_idx;
          end else begin
            grant_d = '0;
            en_d    = 1'b0;
            dis_d   = dis_q;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      dis_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dis_q   <= dis_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.dis_data = dis_q;
  assign bus.disp_en  = en_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_arbiter
// Description : Directed self-checking bench for disp_arbiter with
//               N_REQ=3, MIN_SLICE=4, MAX_SLICE=10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_arbiter;

  localparam int N_REQ = 3;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  disp_arbiter_if #(.N_REQ(N_REQ)) bus ();

  disp_arbiter #(
    .N_REQ     (N_REQ),
    .MIN_SLICE (4),
    .MAX_SLICE (10)
  ) dut (
    .clk_50mhz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    bus.req_data = {d2, d1, d0};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

    rst_n   = 1'b0;
    bus.req = '0;
    set_data(32'h0000_00AA, 32'h1234_5678, 32'hCCCC_0002);

    // 1. Reset state and first winner after reset
    #5;
    check("rst_grant",  32'(bus.grant),    32'h0);
    check("rst_dis",    bus.dis_data,      32'h0);
    check("rst_en",     32'(bus.disp_en),  32'h0);
    step();
    bus.req = 3'b111;
    rst_n   = 1'b1;
    step();
    check("rst_first_grant", 32'(bus.grant), 32'h1);
    check("rst_first_dis",   bus.dis_data,   32'h0000_00AA);
    step(); step();
    #4;
    rst_n = 1'b0;   // mid-cycle, no clock edge
    #1;
    check("arst_grant", 32'(bus.grant),   32'h0);
    check("arst_dis",   bus.dis_data,     32'h0);
    check("arst_en",    32'(bus.disp_en), 32'h0);
    bus.req = '0;
    step();
    rst_n = 1'b1;
    step();

    // 2. Single source with early drop held to MIN_SLICE
    bus.req = 3'b010;
    step();
    check("single_grant", 32'(bus.grant),   32'h2);
    check("single_dis",   bus.dis_data,     32'h1234_5678);
    check("single_en",    32'(bus.disp_en), 32'h1);
    step();
    bus.req = '0;
    step();
    check("single_hold3", 32'(bus.grant), 32'h2);
    step();
    check("single_hold4", 32'(bus.grant), 32'h2);
    step();
    check("single_rel_grant", 32'(bus.grant),   32'h0);
    check("single_rel_en",    32'(bus.disp_en), 32'h0);
    check("single_rel_dis",   bus.dis_data,     32'h1234_5678);

    // 3. Contention from idle: 0 owns for MAX_SLICE then hands to 2
    do_reset();
    bus.req = 3'b101;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("cont_own0_c%0d", i), 32'(bus.grant), 32'h1);
    end
    step();
    check("cont_handover", 32'(bus.grant), 32'h4);
    check("cont_dis",      bus.dis_data,   32'hCCCC_0002);

    // 4. Fairness: all request, 10 cycles each, no gaps
    do_reset();
    bus.req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 10; i++) begin
        step();
        if (s < 3 || i == 0)
          check($sformatf("fair_s%0d_c%0d", s, i), 32'(bus.grant), 32'(seq[s]));
      end
    end
    check("fair_en", 32'(bus.disp_en), 32'h1);

    // 5. Live update then freeze after owner drops
    do_reset();
    bus.req = 3'b001;
    step();
    check("live_first", bus.dis_data, 32'h0000_00AA);
    set_data(32'h0000_00BB, 32'h1234_5678, 32'hCCCC_0002);
    step();
    check("live_update", bus.dis_data, 32'h0000_00BB);
    bus.req = '0;
    set_data(32'h0000_00CC, 32'h1234_5678, 32'hCCCC_0002);
    step();
    check("frozen_c2",       bus.dis_data,   32'h0000_00BB);
    step();
    check("frozen_c3",       bus.dis_data,   32'h0000_00BB);
    check("frozen_c3_grant", 32'(bus.grant), 32'h1);
    step();
    check("frozen_rel_grant", 32'(bus.grant), 32'h0);
    check("frozen_rel_dis",   bus.dis_data,   32'h0000_00BB);

    // 6. No contention past MAX_SLICE, then late contender wins at once
    do_reset();
    bus.req = 3'b100;
    for (int i = 0; i < 30; i++) begin
      step();
      check($sformatf("nocont_c%0d", i), 32'(bus.grant), 32'h4);
    end
    bus.req = 3'b101;
    step();
    check("late_grant", 32'(bus.grant), 32'h1);
    check("late_dis",   bus.dis_data,   32'h0000_00CC);
    check("late_en",    32'(bus.disp_en), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
